// File: rtl/mem_arbiter.sv
// Round-robin arbiter and sequencer for a single-port 2^M x N register array.
// Runs a zero-fill sweep after reset or clr, then grants one requester access per cycle.
module mem_arbiter #(
    parameter int unsigned N = 32,
    parameter int unsigned M = 5,
    parameter int unsigned R = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [R-1:0]   req,
    input  logic [R-1:0]   req_rd,
    input  logic [R*M-1:0] req_addr,
    input  logic [R*N-1:0] req_wdata,
    output logic [R-1:0]   ack,
    output logic [R-1:0]   rsp_valid,
    output logic [N-1:0]   rsp_data,
    input  logic           clr,
    output logic           ready,
    output logic           mem_ctrl,
    output logic [M-1:0]   mem_addr,
    output logic [N-1:0]   mem_write_data,
    input  logic [N-1:0]   mem_read_data
);

    localparam int unsigned   PW        = (R > 1) ? $clog2(R) : 1;
    localparam logic [M-1:0]  LAST_ADDR = '1;
    localparam logic [PW-1:0] LAST_REQ  = PW'(R - 1);

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        state;
    logic [M-1:0]  cnt;
    logic [PW-1:0] ptr;
    logic          grant;
    logic [PW-1:0] win;
    logic [PW-1:0] cand;

    // Sweep write or round-robin pick; idle cycles issue a harmless read of address 0.
    always_comb begin
        grant          = 1'b0;
        win            = '0;
        cand           = '0;
        ack            = '0;
        mem_ctrl       = 1'b1;
        mem_addr       = '0;
        mem_write_data = '0;
        if (reset && state == INIT) begin
            mem_ctrl = 1'b0;
            mem_addr = cnt;
        end else if (reset && state == RUN && !clr) begin
            for (int unsigned k = 0; k < R; k++) begin
                cand = PW'((32'(ptr) + k) % R);
                if (!grant && req[cand]) begin
                    grant = 1'b1;
                    win   = cand;
                end
            end
            if (grant) begin
                ack[win]       = 1'b1;
                mem_ctrl       = req_rd[win];
                mem_addr       = req_addr[32'(win) * M +: M];
                mem_write_data = req_wdata[32'(win) * N +: N];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= INIT;
            cnt       <= '0;
            ptr       <= '0;
            rsp_valid <= '0;
        end else begin
            rsp_valid <= (grant && mem_ctrl) ? (R'(1) << win) : '0;
            case (state)
                INIT: begin
                    cnt <= cnt + M'(1);
                    if (cnt == LAST_ADDR) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (clr) begin
                        state <= INIT;
                        cnt   <= '0;
                    end else if (grant) begin
                        ptr <= (win == LAST_REQ) ? '0 : win + PW'(1);
                    end
                end
            endcase
        end
    end

    assign ready    = (state == RUN);
    assign rsp_data = mem_read_data;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed bench for mem_arbiter against a cycle-level reference model
// and a behavioural register-array memory.
module tb_mem_arbiter;

    localparam int N = 32;
    localparam int M = 5;
    localparam int R = 4;
    localparam int D = 1 << M;

    logic           clk = 1'b0;
    logic           reset;
    logic [R-1:0]   req, req_rd;
    logic [R*M-1:0] req_addr;
    logic [R*N-1:0] req_wdata;
    logic [R-1:0]   ack, rsp_valid;
    logic [N-1:0]   rsp_data;
    logic           clr, ready, mem_ctrl;
    logic [M-1:0]   mem_addr;
    logic [N-1:0]   mem_write_data, mem_read_data;

    always #5 clk = ~clk;

    mem_arbiter #(.N(N), .M(M), .R(R)) dut (
        .clk(clk), .reset(reset), .req(req), .req_rd(req_rd), .req_addr(req_addr),
        .req_wdata(req_wdata), .ack(ack), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .clr(clr), .ready(ready), .mem_ctrl(mem_ctrl), .mem_addr(mem_addr),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
    );

    // Memory: writes when mem_ctrl==0, registered read data otherwise.
    logic [N-1:0] mem [D];
    always @(posedge clk) begin
        if (!mem_ctrl) mem[mem_addr] <= mem_write_data;
        else           mem_read_data <= mem[mem_addr];
    end

    // Reference model state
    bit           m_init;
    logic [M-1:0] m_cnt;
    int           m_ptr;
    logic [N-1:0] m_mem [D];
    logic [R-1:0] m_rsp;
    logic [N-1:0] m_rsp_data;
    int           errors = 0;
    int           checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_init = 1'b1;
        m_cnt  = '0;
        m_ptr  = 0;
        m_rsp  = '0;
    endtask

    // One clock: compare outputs mid-cycle, then advance the model across the edge.
    task automatic cyc();
        logic [R-1:0] e_ack;
        logic         e_ctrl;
        logic [M-1:0] e_addr;
        logic [N-1:0] e_wd;
        int           win;
        @(negedge clk);
        e_ack = '0; e_ctrl = 1'b1; e_addr = '0; e_wd = '0; win = -1;
        if (reset) begin
            if (m_init) begin
                e_ctrl = 1'b0;
                e_addr = m_cnt;
            end else if (!clr) begin
                for (int k = 0; k < R; k++) begin
                    int j;
                    logic [R-1:0] rq;
                    j  = (m_ptr + k) % R;
                    rq = req >> j;
                    if (win < 0 && rq[0]) win = j;
                end
                if (win >= 0) begin
                    logic [R-1:0] rd;
                    rd     = req_rd >> win;
                    e_ack  = R'(1) << win;
                    e_ctrl = rd[0];
                    e_addr = M'(req_addr >> (win * M));
                    e_wd   = N'(req_wdata >> (win * N));
                end
            end
        end
        check("ack", 64'(ack), 64'(e_ack));
        check("mem_ctrl", 64'(mem_ctrl), 64'(e_ctrl));
        check("mem_addr", 64'(mem_addr), 64'(e_addr));
        if (!e_ctrl || !reset) check("mem_write_data", 64'(mem_write_data), 64'(e_wd));
        check("ready", 64'(ready), 64'(!m_init));
        check("rsp_valid", 64'(rsp_valid), 64'(m_rsp));
        if (m_rsp != '0) check("rsp_data", 64'(rsp_data), 64'(m_rsp_data));
        @(posedge clk);
        if (!reset) begin
            model_reset();
        end else begin
            m_rsp = '0;
            if (m_init) begin
                m_mem[m_cnt] = '0;
                if (m_cnt == M'(D - 1)) m_init = 1'b0;
                m_cnt = m_cnt + M'(1);
            end else if (clr) begin
                m_init = 1'b1;
                m_cnt  = '0;
            end else if (win >= 0) begin
                m_ptr = (win + 1) % R;
                if (e_ctrl) begin
                    m_rsp      = R'(1) << win;
                    m_rsp_data = m_mem[e_addr];
                end else begin
                    m_mem[e_addr] = e_wd;
                end
            end
        end
        #1;
    endtask

    task automatic clear_reqs();
        req = '0; req_rd = '0; req_addr = '0; req_wdata = '0;
    endtask

    task automatic set_req(input int i, input bit rd, input int a, input logic [N-1:0] wd);
        logic [R*M-1:0] am;
        logic [R*N-1:0] dm;
        am        = (R*M)'({M{1'b1}}) << (i * M);
        dm        = (R*N)'({N{1'b1}}) << (i * N);
        req       = req | (R'(1) << i);
        req_rd    = rd ? (req_rd | (R'(1) << i)) : (req_rd & ~(R'(1) << i));
        req_addr  = (req_addr & ~am) | ((R*M)'(M'(a)) << (i * M));
        req_wdata = (req_wdata & ~dm) | ((R*N)'(wd) << (i * N));
    endtask

    initial begin
        clear_reqs();
        clr   = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;
        model_reset();
        repeat (2) cyc();
        reset = 1'b1;

        // Idle sweep, then read back every address
        repeat (33) cyc();
        for (int a = 0; a < D; a++) begin
            clear_reqs(); set_req(0, 1'b1, a, '0); cyc();
        end
        clear_reqs(); cyc();

        // Single requester write then read
        set_req(1, 1'b0, 7, 32'hDEADBEEF); cyc();
        clear_reqs(); set_req(1, 1'b1, 7, '0); cyc();
        clear_reqs(); cyc();

        // All four requesters reading continuously
        for (int i = 0; i < R; i++) set_req(i, 1'b1, i * 3 + 7, '0);
        repeat (12) cyc();
        clear_reqs(); cyc();

        // clr beats a pending read, which then reads zero after the sweep
        set_req(2, 1'b0, 3, 32'h55); cyc();
        clear_reqs(); set_req(2, 1'b1, 3, '0); clr = 1'b1; cyc();
        clr = 1'b0; repeat (34) cyc();
        clear_reqs(); cyc();

        // Read granted just before clr
        set_req(0, 1'b1, 7, '0); cyc();
        clear_reqs(); clr = 1'b1; cyc();
        clr = 1'b0; repeat (34) cyc();

        // Reset mid-sweep with a request held
        reset = 1'b0; cyc();
        reset = 1'b1; set_req(0, 1'b1, 5, '0);
        repeat (10) cyc();
        reset = 1'b0; cyc();
        reset = 1'b1; repeat (34) cyc();
        clear_reqs(); cyc();

        // Random traffic with occasional clr and reset
        for (int n = 0; n < 1500; n++) begin
            req       = R'($urandom);
            req_rd    = R'($urandom);
            req_addr  = (R*M)'({$urandom, $urandom});
            if (n % 2 == 0) req_addr = req_addr & {R{M'(7)}};
            req_wdata = (R*N)'({$urandom, $urandom, $urandom, $urandom});
            clr       = ($urandom_range(0, 49) == 0);
            reset     = ($urandom_range(0, 299) != 0);
            cyc();
        end
        reset = 1'b1; clr = 1'b0; clear_reqs(); cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Round-robin arbiter and sequencer in front of the single-port 2^M x N register-array memory. Shares the memory's one access per cycle among R requesters, routes read data back to the issuing requester, and runs a zero-fill sweep of the whole array after reset or on command. Sits between client blocks and the memory's `mem_ctrl`/`addr`/`write_data`/`read_data` port.

## Interface
- `N`, 32, data width
- `M`, 5, address width (2^M words)
- `R`, 4, number of requesters (2..8)

- `clk`  in  1  clock, all logic on rising edge
- `reset`  in  1  synchronous, active-low reset
- `req`  in  R  per-requester access request, level
- `req_rd`  in  R  per-requester op: 1 read, 0 write (memory convention)
- `req_addr`  in  R*M  per-requester address, requester i at [i*M +: M]
- `req_wdata`  in  R*N  per-requester write data, requester i at [i*N +: N]
- `ack`  out  R  one-hot grant, combinational; request consumed on the edge it is high
- `rsp_valid`  out  R  one-hot, registered; read data valid for that requester
- `rsp_data`  out  N  read data, equals `mem_read_data`
- `clr`  in  1  pulse: restart zero-fill sweep
- `ready`  out  1  registered; 1 in RUN state
- `mem_ctrl`  out  1  to memory: 0 write, 1 read
- `mem_addr`  out  M  to memory address
- `mem_write_data`  out  N  to memory write data
- `mem_read_data`  in  N  from memory read data (registered inside memory)

## Operation
- States: INIT (zero-fill sweep), RUN. Reset (reset==0 at an edge) -> INIT, sweep counter 0, pointer 0.
- Memory writes whenever `mem_ctrl`==0, so every cycle not issuing a write drives `mem_ctrl`=1, `mem_addr`=0 (harmless idle read). This holds while `reset` is low too.
- INIT: each cycle `mem_ctrl`=0, `mem_addr`=counter, `mem_write_data`=0; counter +1. After writing address 2^M-1, state -> RUN. `ack`=0 throughout; requests held, not dropped.
- RUN arbitration: scan requesters from pointer `ptr` upward modulo R; first with `req`=1 wins. `ack`=one-hot of winner; `mem_ctrl`=winner `req_rd`, `mem_addr`/`mem_write_data` = winner's fields. After a grant to i, `ptr`=(i+1) mod R; no grant -> `ptr` unchanged.
- Fairness: a requester holding `req` high is granted within R cycles.
- Read grant to i at edge k -> `rsp_valid[i]`=1 during cycle k+1, `rsp_data`=`mem_read_data`. Write grants produce no response.
- `clr` in RUN: no grant that cycle (clr wins over all requests), -> INIT next edge, counter 0. `clr` in INIT ignored (sweep not restarted).
- A read granted the cycle before a `clr` still returns `rsp_valid` in the first INIT cycle with correct data (sweep writes do not update `mem_read_data`).
- `rsp_data` is don't-care when `rsp_valid`==0.

## Timing
- Reset values after an edge with `reset`==0: `ack`=0, `rsp_valid`=0, `ready`=0, `mem_ctrl`=1, `mem_addr`=0, `mem_write_data`=0, `ptr`=0.
- Sweep length 2^M cycles; `ready` rises the edge after the last sweep write (first RUN cycle), first `ack` possible that same cycle.
- Throughput: one access per cycle, back-to-back any mix of reads/writes across requesters.
- Read latency: 1 cycle from grant to `rsp_valid`.
- Write at edge k is visible to a read granted at edge k+1 (same address, new data).
- Reset mid-sweep or mid-RUN: in-flight `rsp_valid` cleared, sweep restarts from 0.
- `ack`, `mem_*` outputs combinational from state, `ptr`, `req*`, `clr`; `rsp_valid`, `ready`, `ptr`, counter registered.

## Test plan
- Reset then idle: `ready`=0 for exactly 32 cycles with `mem_ctrl`=0, `mem_addr` 0..31, data 0; then `ready`=1, `mem_ctrl`=1; reads of all 32 addresses return 0.
- Single requester: req1 writes 0xDEADBEEF to addr 7, next cycle reads addr 7 -> `ack[1]` both cycles, `rsp_valid`=4'b0010 one cycle after read grant, `rsp_data`=0xDEADBEEF.
- All four hold `req`=1 (reads, ptr=0): grants 0,1,2,3,0,... one per cycle; each `rsp_valid` one-hot follows its grant by one cycle.
- Requests during sweep: req0 asserted from reset release -> no `ack` until first RUN cycle, then `ack[0]`=1.
- `clr` in RUN same cycle as req2 read of addr 3 holding 0x55: no `ack`, 32-cycle sweep, then req2 granted and reads 0.
- Reset low mid-sweep (counter=10) for one edge: `mem_ctrl`=1 while low, sweep restarts at addr 0, full 32 cycles to `ready`.
